question_ctrl: RTL
==================

// Module: question_ctrl
// PURPOSE
//  Sequences the question-mark sprite renderer: supplies its origin (x0,y0) and enable.
//  On start, the sprite drops from Y_START to Y_TARGET, advancing one step per frame.
//  It then blinks until the player acknowledges or a frame timeout expires.
//  Sits between game FSM (start/ack) and the pixel-level question renderer; all timing is frame-based.
// PARAMETERS
//  Y_START        10'd0    y0 at drop start (pixels)
//  Y_TARGET       10'd200  resting y0; sprite box must fit: Y_TARGET <= V_ACTIVE-SPR_H
//  DROP_STEP      4        y0 increment per frame_tick during drop (1..63)
//  BLINK_FRAMES   16       frames per en half-period while waiting (>=1)
//  TIMEOUT_FRAMES 600      frames in WAIT before timeout (>=1)
// PORTS
//  clk         in   1   pixel/system clock
//  rst_n       in   1   asynchronous active-low reset
//  frame_tick  in   1   one-cycle pulse per frame (start of vblank)
//  start       in   1   one-cycle request to show a question
//  x_req       in   10  requested sprite x origin, sampled with start
//  ack         in   1   one-cycle player-answer pulse
//  x0          out  10  sprite x origin to renderer
//  y0          out  10  sprite y origin to renderer
//  en          out  1   sprite enable to renderer
//  busy        out  1   high in DROP or WAIT
//  answered    out  1   one-cycle pulse: ack accepted
//  timeout     out  1   one-cycle pulse: TIMEOUT_FRAMES elapsed without ack
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, x0=0, y0=Y_START, en=0, busy=0, answered=0, timeout=0.
//    Reset is honoured at any time, including mid-DROP/WAIT; no pulse is emitted.
//  - IDLE: en=0. start -> DROP next cycle.
//    x0 <= min(x_req, H_ACTIVE-SPR_W) (i.e. clamped to 600). y0 <= Y_START.
//  - DROP: en=1. On each frame_tick, compute s = y0+DROP_STEP in 11 bits (no wrap).
//    If s >= Y_TARGET: y0 <= Y_TARGET and enter WAIT on the same edge; else y0 <= s.
//    ack is ignored in DROP.
//  - WAIT: entry loads blink counter = BLINK_FRAMES-1, timeout counter = TIMEOUT_FRAMES-1, en=1.
//    Each frame_tick decrements both counters. On blink count 0: toggle en, reload.
//    On timeout count 0 with a frame_tick: timeout=1 for one cycle, go IDLE, en=0.
//  - ack in WAIT (any cycle): answered=1 for one cycle, go IDLE, en=0.
//    ack and timeout expiry in the same cycle: ack wins; answered only, no timeout.
//  - start while busy: ignored; x_req not resampled.
//  - start and ack in the same IDLE cycle: start taken, ack dropped.
//  - frame_tick absent: state, y0 and en hold indefinitely.
//  - answered/timeout are mutually exclusive and assert only on a WAIT->IDLE edge.
// STRUCTURE
//  - Shared include question_defs.vh holds:
//    H_ACTIVE=640, V_ACTIVE=480, SPR_W=40, SPR_H=56, and state codes IDLE/DROP/WAIT (2-bit).
//  - One sub-module: question_frame_timer (WIDTH param; load, frame_tick decrement, zero flag).
//    It is instantiated twice: blink (WIDTH 5) and timeout (WIDTH 10).
//  - Top holds the FSM, y0 adder/clamp and x clamp.
// TESTING
//  1. Reset mid-DROP (y0=40): deassert rst_n -> all outputs at reset values immediately; IDLE after release.
//  2. start, x_req=100, defaults -> x0=100, en=1; y0=4,8,..,196,200 on ticks 1..50; WAIT after tick 50.
//  3. x_req=630 -> x0=600; Y_TARGET=202 -> y0 clamps 200->202 (no overshoot to 204).
//  4. WAIT, BLINK_FRAMES=16 -> en=1 for ticks 1..15, toggles to 0 at tick 16, back to 1 at tick 32.
//  5. TIMEOUT_FRAMES=600, no ack -> timeout pulse one cycle after tick 600, en=0, busy=0;
//     ack on that same cycle -> answered only.
//  6. start during WAIT with x_req=0 -> ignored (x0 unchanged); ack during DROP -> no answered, drop continues.

Source files
------------

// File: rtl/question_ctrl_pkg.sv
// Shared definitions for the question-mark sprite sequencer.
//   - Display and sprite geometry (active area, sprite box size).
//   - Derived origin limits so the sprite box always stays on screen.
//   - FSM state encoding shared by the controller and anything observing it.
//   - A small clamp helper used for both the x origin and the resting y origin.
package question_ctrl_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPR_W    = 40;
  localparam int SPR_H    = 56;

  // Largest origin that still keeps the whole sprite box inside the active area.
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SPR_W);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SPR_H);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DROP = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/question_frame_timer.sv
// Frame-based down counter.
//   clk, rst_n   : clock, asynchronous active-low reset (count resets to 0)
//   load_i       : load load_val_i (takes priority over a decrement)
//   load_val_i   : value loaded on load_i
//   tick_i       : frame pulse; decrements the count while it is non-zero
//   zero_o       : count is zero (combinational from the count register)
// The owner decides what a tick at zero means (reload, expiry); the counter
// simply parks at zero until it is loaded again.
module question_frame_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/question_ctrl.sv
// Question-mark sprite sequencer: drives origin and enable of the renderer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_tick   : one-cycle pulse per frame
//   start        : request to show a question (x_req sampled with it)
//   x_req        : requested sprite x origin
//   ack          : player answered
//   x0, y0, en   : sprite origin and enable (registered)
//   busy         : high while dropping or waiting (registered)
//   answered     : one-cycle pulse, ack accepted while waiting
//   timeout      : one-cycle pulse, wait period expired without ack
//   state_dbg    : current FSM state (question_ctrl_pkg::state_e encoding)
// Handshake: start and ack are single-cycle pulses with no back-pressure;
// start is only taken in IDLE and ack only in WAIT, all other pulses are
// dropped. answered/timeout are single-cycle pulses with no ready.
module question_ctrl
  import question_ctrl_pkg::*;
#(
  parameter logic [9:0] Y_START        = 10'd0,
  parameter logic [9:0] Y_TARGET       = 10'd200,
  parameter int         DROP_STEP      = 4,
  parameter int         BLINK_FRAMES   = 16,
  parameter int         TIMEOUT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] x_req,
  input  logic       ack,
  output logic [9:0] x0,
  output logic [9:0] y0,
  output logic       en,
  output logic       busy,
  output logic       answered,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  // A target below the screen would push the sprite box off the bottom.
  localparam logic [9:0] Y_TGT      = clamp10(Y_TARGET, Y_MAX);
  localparam logic [4:0] BLINK_LOAD = 5'(BLINK_FRAMES - 1);
  localparam logic [9:0] TMO_LOAD   = 10'(TIMEOUT_FRAMES - 1);

  state_e     state_q, state_d;
  logic [9:0] x0_q, x0_d;
  logic [9:0] y0_q, y0_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       answered_q, answered_d;
  logic       timeout_q, timeout_d;

  logic       blink_load, tmo_load;
  logic       blink_zero, tmo_zero;
  logic [10:0] drop_sum;

  // Eleven bits so a step past 1023 cannot wrap and look like "not there yet".
  assign drop_sum = {1'b0, y0_q} + 11'(DROP_STEP);

  question_frame_timer #(.WIDTH(5)) u_blink_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (blink_load),
    .load_val_i (BLINK_LOAD),
    .tick_i     (frame_tick),
    .zero_o     (blink_zero)
  );

  question_frame_timer #(.WIDTH(10)) u_timeout_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .tick_i     (frame_tick),
    .zero_o     (tmo_zero)
  );

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    en_d       = en_q;
    answered_d = 1'b0;
    timeout_d  = 1'b0;
    blink_load = 1'b0;
    tmo_load   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (start) begin
          state_d = ST_DROP;
          x0_d    = clamp10(x_req, X_MAX);
          y0_d    = Y_START;
          en_d    = 1'b1;
        end
      end

      ST_DROP: begin
        en_d = 1'b1;
        if (frame_tick) begin
          if (drop_sum >= {1'b0, Y_TGT}) begin
            // Land exactly on the target and arm both timers on the same edge.
            y0_d       = Y_TGT;
            state_d    = ST_WAIT;
            blink_load = 1'b1;
            tmo_load   = 1'b1;
          end else begin
            y0_d = drop_sum[9:0];
          end
        end
      end

      ST_WAIT: begin
        // ack outranks an expiry landing in the same cycle.
        if (ack) begin
          answered_d = 1'b1;
          state_d    = ST_IDLE;
          en_d       = 1'b0;
        end else if (frame_tick && tmo_zero) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          en_d      = 1'b0;
        end else if (frame_tick && blink_zero) begin
          en_d       = ~en_q;
          blink_load = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= Y_START;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      answered_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      answered_q <= answered_d;
      timeout_q  <= timeout_d;
    end
  end

  assign x0        = x0_q;
  assign y0        = y0_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign answered  = answered_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule
